// File: rtl/axis_bernoulli_tg.sv
`default_nettype none
// ============================================================================
// Module      : axis_bernoulli_tg
// Description : Bernoulli-injection AXI-Stream traffic generator. Optional
//               macro AXIS_TG_TIMESTAMP_EN puts the latched ticks value in
//               the upper half of tdata.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_bernoulli_tg #(
    parameter logic [31:0] SEED          = 32'd1,
    parameter int          COUNT_WIDTH   = 32,
    parameter int          TID           = 0,
    parameter int          TDATA_WIDTH   = 64,
    parameter int          TDEST_WIDTH   = 2,
    parameter int          TID_WIDTH     = 2,
    parameter int          NUM_ROUTERS   = 4,
    parameter int          PACKET_FLITS  = 2,
    parameter int          BACKLOG_WIDTH = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [15:0]                             load,
    input  logic [COUNT_WIDTH-1:0]                  num_packets,
    input  logic                                    start,
    input  logic [TDATA_WIDTH/2-1:0]                ticks,
    output logic                                    done,
    output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] sent_packets,
    output logic [COUNT_WIDTH-1:0]                  total_sent_packets,
    output logic                                    backlog_overflow,
    output logic                                    axis_out_tvalid,
    input  logic                                    axis_out_tready,
    output logic [TDATA_WIDTH-1:0]                  axis_out_tdata,
    output logic                                    axis_out_tlast,
    output logic [TID_WIDTH-1:0]                    axis_out_tid,
    output logic [TDEST_WIDTH-1:0]                  axis_out_tdest
);

    localparam int c_half   = TDATA_WIDTH / 2;
    localparam int c_flit_w = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;

    typedef logic [c_half-1:0]   half_t;
    typedef logic [c_flit_w-1:0] flit_t;

    localparam logic [31:0]            c_taps      = 32'h8020_0003;
    localparam logic [31:0]            c_seed      = SEED | 32'd1;
    localparam flit_t                  c_last_flit = flit_t'(PACKET_FLITS - 1);
    localparam logic [TDEST_WIDTH-1:0] c_own_dest  = TDEST_WIDTH'(TID);
    localparam logic [TDEST_WIDTH-1:0] c_alt_dest  = TDEST_WIDTH'((TID + 1) % NUM_ROUTERS);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_send = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]                              r_state;
    logic [1:0]                              w_state_next;
    logic [31:0]                             r_lfsr;
    logic [31:0]                             w_lfsr_next;
    logic [COUNT_WIDTH-1:0]                  r_generated;
    logic [BACKLOG_WIDTH-1:0]                r_backlog;
    logic [BACKLOG_WIDTH-1:0]                w_backlog_next;
    logic                                    r_overflow;
    flit_t                                   r_flit;
    half_t                                   r_seq;
    logic [TDEST_WIDTH-1:0]                  r_tdest;
    logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] r_sent;
    logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] w_sent_next;
    logic [COUNT_WIDTH-1:0]                  r_total;
    logic [COUNT_WIDTH-1:0]                  w_seq_new;
    logic [TDEST_WIDTH-1:0]                  w_dest_raw;
    logic [TDEST_WIDTH-1:0]                  w_dest_new;
    logic [15:0]                             w_draw;
    logic [15:0]                             w_dsel;
    logic                                    w_fire;
    logic                                    w_hs;
    logic                                    w_last_hs;
    logic                                    w_drop;
    logic                                    w_pkt_start;

    assign w_draw      = r_lfsr[15:0];
    assign w_dsel      = r_lfsr[31:16];
    assign w_lfsr_next = r_lfsr[0] ? ({1'b0, r_lfsr[31:1]} ^ c_taps) : {1'b0, r_lfsr[31:1]};

    assign w_fire    = start && (r_generated < num_packets) && (w_draw < load);
    assign w_hs      = axis_out_tvalid && axis_out_tready;
    assign w_last_hs = w_hs && axis_out_tlast;
    assign w_drop    = w_fire && !w_last_hs && (&r_backlog);

    // Simultaneous fire and last-flit handshake cancel, so a full backlog is not dropped then.
    always_comb begin
        w_backlog_next = r_backlog;
        if (w_fire && !w_last_hs && !(&r_backlog))
            w_backlog_next = r_backlog + BACKLOG_WIDTH'(1);
        else if (!w_fire && w_last_hs)
            w_backlog_next = r_backlog - BACKLOG_WIDTH'(1);
    end

    assign w_dest_raw = TDEST_WIDTH'({16'd0, w_dsel} % 32'(NUM_ROUTERS));
    assign w_dest_new = (NUM_ROUTERS > 1 && w_dest_raw == c_own_dest) ? c_alt_dest : w_dest_raw;

    // The sequence number of a new packet sees the count of the packet completing this cycle.
    always_comb begin
        w_sent_next = r_sent;
        w_seq_new   = '0;
        for (int i = 0; i < NUM_ROUTERS; i++) begin
            if (w_last_hs && r_tdest == TDEST_WIDTH'(i))
                w_sent_next[i] = r_sent[i] + COUNT_WIDTH'(1);
        end
        for (int i = 0; i < NUM_ROUTERS; i++) begin
            if (w_dest_new == TDEST_WIDTH'(i))
                w_seq_new = w_sent_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_st_idle;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (r_backlog != '0)
                    w_state_next = c_st_send;
                else if (r_generated == num_packets)
                    w_state_next = c_st_done;
            end
            c_st_send: begin
                if (w_last_hs && w_backlog_next == '0)
                    w_state_next = c_st_idle;
            end
            c_st_done: w_state_next = c_st_done;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        axis_out_tvalid = (r_state == c_st_send);
        axis_out_tlast  = (r_state == c_st_send) && (r_flit == c_last_flit);
        done            = (r_state == c_st_done);
    end

    assign w_pkt_start = (w_state_next == c_st_send) && ((r_state != c_st_send) || w_last_hs);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= c_seed;
            r_generated <= '0;
            r_backlog   <= '0;
            r_overflow  <= 1'b0;
            r_flit      <= '0;
            r_seq       <= '0;
            r_tdest     <= '0;
            r_sent      <= '0;
            r_total     <= '0;
        end else begin
            r_lfsr    <= w_lfsr_next;
            r_backlog <= w_backlog_next;
            r_sent    <= w_sent_next;
            if (w_fire)
                r_generated <= r_generated + COUNT_WIDTH'(1);
            if (w_drop)
                r_overflow <= 1'b1;
            if (w_last_hs)
                r_total <= r_total + COUNT_WIDTH'(1);
            if (w_pkt_start) begin
                r_flit  <= '0;
                r_seq   <= half_t'(w_seq_new);
                r_tdest <= w_dest_new;
            end else if (w_last_hs) begin
                r_flit <= '0;
            end else if (w_hs) begin
                r_flit <= r_flit + flit_t'(1);
            end
        end
    end

`ifdef AXIS_TG_TIMESTAMP_EN
    half_t r_ts;

    always_ff @(posedge clk) begin
        if (rst)
            r_ts <= '0;
        else if (w_pkt_start)
            r_ts <= ticks;
    end

    assign axis_out_tdata = {r_ts, r_seq};
`else
    logic w_unused_ticks;
    assign w_unused_ticks = ^ticks;
    assign axis_out_tdata = {half_t'(0), r_seq};
`endif

    assign axis_out_tdest     = r_tdest;
    assign axis_out_tid       = TID_WIDTH'(TID);
    assign sent_packets       = r_sent;
    assign total_sent_packets = r_total;
    assign backlog_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_axis_bernoulli_tg.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_bernoulli_tg
// Description : Randomised scoreboard bench for axis_bernoulli_tg against a
//               packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_bernoulli_tg;

    localparam int          CW     = 32;
    localparam int          TDW    = 64;
    localparam int          NR     = 4;
    localparam int          PF     = 2;
    localparam int          BW     = 2;
    localparam int          TIDV   = 2;
    localparam logic [31:0] SEEDV  = 32'h1234_5678;
    localparam int          BL_MAX = (1 << BW) - 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic                    tready = 1'b0;
    logic [15:0]             load = '0;
    logic [CW-1:0]           num_packets = '0;
    logic [TDW/2-1:0]        ticks = '0;
    logic                    done;
    logic [NR-1:0][CW-1:0]   sent_packets;
    logic [CW-1:0]           total_sent_packets;
    logic                    backlog_overflow;
    logic                    axis_out_tvalid;
    logic [TDW-1:0]          axis_out_tdata;
    logic                    axis_out_tlast;
    logic [1:0]              axis_out_tid;
    logic [1:0]              axis_out_tdest;

    axis_bernoulli_tg #(
        .SEED(SEEDV), .COUNT_WIDTH(CW), .TID(TIDV), .TDATA_WIDTH(TDW),
        .TDEST_WIDTH(2), .TID_WIDTH(2), .NUM_ROUTERS(NR),
        .PACKET_FLITS(PF), .BACKLOG_WIDTH(BW)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .num_packets(num_packets),
        .start(start), .ticks(ticks), .done(done),
        .sent_packets(sent_packets), .total_sent_packets(total_sent_packets),
        .backlog_overflow(backlog_overflow),
        .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(tready),
        .axis_out_tdata(axis_out_tdata), .axis_out_tlast(axis_out_tlast),
        .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1 ticks = ticks + 32'd1;
    end

    int n_checks = 0;
    int n_errors = 0;
    int hs_count = 0;
    bit mon_en   = 1'b0;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  dest;
        logic        last;
    } exp_flit_t;

    exp_flit_t   exp_q[$];
    logic [31:0] m_lfsr;
    logic [31:0] m_gen;
    logic [31:0] m_sent[NR];
    logic [31:0] m_total;
    int          m_backlog;
    int          m_flit;
    int          m_dest;
    bit          m_ovf, m_busy, m_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    // A packet is described as its list of flits the moment the generator begins it.
    task automatic new_packet();
        exp_flit_t   f;
        logic [31:0] ts;
        int          d;
        d = int'(m_lfsr[31:16]) % NR;
        if (NR > 1 && d == TIDV) d = (TIDV + 1) % NR;
`ifdef AXIS_TG_TIMESTAMP_EN
        ts = ticks;
`else
        ts = 32'd0;
`endif
        for (int k = 0; k < PF; k++) begin
            f.data = {ts, m_sent[d]};
            f.dest = 2'(d);
            f.last = (k == PF - 1);
            exp_q.push_back(f);
        end
        m_dest = d;
        m_busy = 1'b1;
        m_flit = 0;
    endtask

    task automatic model_step();
        bit          fire, last;
        int          old_bl;
        logic [31:0] old_gen;
        if (rst) begin
            m_lfsr = SEEDV | 32'd1;
            m_gen = '0; m_total = '0; m_backlog = 0; m_flit = 0; m_dest = 0;
            m_ovf = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            for (int i = 0; i < NR; i++) m_sent[i] = '0;
            exp_q.delete();
            mon_en = 1'b1;
        end else begin
            old_bl  = m_backlog;
            old_gen = m_gen;
            fire = start && (m_gen < num_packets) && (m_lfsr[15:0] < load);
            last = m_busy && tready && (m_flit == PF - 1);
            if (fire && !last) begin
                if (m_backlog == BL_MAX) m_ovf = 1'b1;
                else m_backlog++;
            end else if (!fire && last) begin
                m_backlog--;
            end
            if (fire) m_gen++;
            if (last) begin
                m_sent[m_dest]++;
                m_total++;
            end
            if (m_busy) begin
                if (last) begin
                    if (m_backlog > 0) new_packet();
                    else m_busy = 1'b0;
                end else if (tready) begin
                    m_flit++;
                end
            end else if (!m_done) begin
                if (old_bl > 0) new_packet();
                else if (old_gen == num_packets) m_done = 1'b1;
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic monitor_step();
        check("tvalid", 64'(axis_out_tvalid), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        check("overflow", 64'(backlog_overflow), 64'(m_ovf));
        check("total_sent", 64'(total_sent_packets), 64'(m_total));
        check("tid", 64'(axis_out_tid), 64'(TIDV));
        for (int i = 0; i < NR; i++) check("sent_packets", 64'(sent_packets[i]), 64'(m_sent[i]));
        if (axis_out_tvalid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL flit_unexpected: got a valid flit, expected none pending at %0t", $time);
            end else begin
                check("tdata", axis_out_tdata, exp_q[0].data);
                check("tdest", 64'(axis_out_tdest), 64'(exp_q[0].dest));
                check("tlast", 64'(axis_out_tlast), 64'(exp_q[0].last));
                if (tready) begin
                    check("tdest_not_own", 64'(axis_out_tdest != 2'(TIDV)), 64'(1));
                    void'(exp_q.pop_front());
                    hs_count++;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (mon_en) monitor_step();
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            step(1);
            n++;
        end
        check({name, "_done"}, 64'(done), 64'(1));
    endtask

    initial begin
        int hs0;
        int sum;
        bit hit;

        // Reset state
        step(3);
        @(negedge clk);
        check("rst_tvalid", 64'(axis_out_tvalid), 64'(0));
        check("rst_tlast", 64'(axis_out_tlast), 64'(0));
        check("rst_tdata", axis_out_tdata, 64'(0));
        check("rst_tdest", 64'(axis_out_tdest), 64'(0));
        check("rst_total", 64'(total_sent_packets), 64'(0));

        // num_packets=0: done right after reset release, start irrelevant
        num_packets = '0; start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("zero_pkts_done", 64'(done), 64'(1));

        // load=0 never injects
        load = 16'h0000; start = 1'b1; num_packets = 32'd50; tready = 1'b1;
        do_reset();
        step(1000);
        @(negedge clk);
        check("load0_done", 64'(done), 64'(0));
        check("load0_total", 64'(total_sent_packets), 64'(0));
        check("load0_tvalid", 64'(axis_out_tvalid), 64'(0));

        // Full load, four packets, always ready
        load = 16'hFFFF; num_packets = 32'd4; tready = 1'b1; start = 1'b1;
        do_reset();
        hs0 = hs_count;
        wait_done("full4", 200);
        check("full4_handshakes", 64'(hs_count - hs0), 64'(8));
        check("full4_total", 64'(total_sent_packets), 64'(4));

        // Saturating backlog, then a 20-cycle stall mid-packet
        load = 16'hFFFF; num_packets = 32'd12; tready = 1'b0; start = 1'b1;
        do_reset();
        step(10);
        check("sat_overflow", 64'(backlog_overflow), 64'(1));
        tready = 1'b1;
        step(1);
        tready = 1'b0;
        step(20);
        tready = 1'b1;
        wait_done("stall", 500);
        check("sat_overflow_sticky", 64'(backlog_overflow), 64'(1));

        // Randomised run with load changes, backpressure and a start gap
        num_packets = 32'd1500; start = 1'b1; load = 16'h4000; tready = 1'b1;
        do_reset();
        for (int c = 0; c < 30000 && done !== 1'b1; c++) begin
            tready = ($urandom_range(0, 3) != 0);
            if (c % 200 == 0) load = 16'($urandom_range(16'h0800, 16'hF000));
            start = !(c >= 400 && c < 700);
            step(1);
        end
        @(negedge clk);
        check("rand_done", 64'(done), 64'(1));
        sum = 0;
        for (int i = 0; i < NR; i++) sum += int'(sent_packets[i]);
        check("rand_sum_sent", 64'(sum), 64'(m_total));
        check("rand_own_dest_unused", 64'(sent_packets[TIDV]), 64'(0));

        // Reset during the second flit of a packet, then a fresh run
        load = 16'hFFFF; num_packets = 32'd10; tready = 1'b1; start = 1'b1;
        do_reset();
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (m_busy && m_flit == 1 && sent_packets[0] + sent_packets[1] + sent_packets[3] != 0) hit = 1'b1;
        end
        check("midrst_reached", 64'(hit), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_tvalid", 64'(axis_out_tvalid), 64'(0));
        check("midrst_total", 64'(total_sent_packets), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_overflow", 64'(backlog_overflow), 64'(0));
        wait_done("midrst", 300);
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
